// File: rtl/valid_serializer.sv
// Wide-to-narrow valid/ready serializer: one word of width*ratio bits leaves as ratio beats of width bits.
// Optional macro VALID_SERIALIZER_MSB_FIRST_EN emits the most significant slice first; default is LSB first.
module valid_serializer #(
    parameter int width = 4,
    parameter int ratio = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_up_i,
    input  logic [width*ratio-1:0]   data_up_i,
    output logic                     ready_up_o,
    output logic                     valid_down_o,
    output logic [width-1:0]         data_down_o,
    input  logic                     ready_down_i
);

    // state | meaning
    // IDLE  | no beat offered, valid_down low, any wide word is accepted
    // BUSY  | beat cnt_q of buf_q offered, valid_down high

    localparam int CW = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [CW-1:0] LAST = CW'(ratio - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [width*ratio-1:0]   buf_q, buf_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            sel;
    logic                     last;
    logic                     busy;
    logic                     up_hs;
    logic                     dn_hs;

    assign busy  = (state_q == BUSY);
    assign last  = (cnt_q == LAST);
    assign up_hs = valid_up_i && ready_up_o;
    assign dn_hs = busy && ready_down_i;

    // Only the last beat's acceptance opens the upstream side, which gives a bubble-free reload.
    assign ready_up_o   = !busy || (ready_down_i && last);
    assign valid_down_o = busy;

`ifdef VALID_SERIALIZER_MSB_FIRST_EN
    assign sel = LAST - cnt_q;
`else
    assign sel = cnt_q;
`endif

    assign data_down_o = buf_q[int'(sel) * width +: width];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        if (up_hs) begin
            buf_d   = data_up_i;
            cnt_d   = '0;
            state_d = BUSY;
        end else if (dn_hs && last) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (dn_hs) begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_valid_serializer.sv
// Scoreboard bench for valid_serializer (width=4, ratio=4): expected beats are queued at each up handshake.
module tb_valid_serializer;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_up_i;
    logic [15:0] data_up_i;
    logic        ready_up_o;
    logic        valid_down_o;
    logic [3:0]  data_down_o;
    logic        ready_down_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    valid_serializer #(.width(4), .ratio(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_up_i   (valid_up_i),
        .data_up_i    (data_up_i),
        .ready_up_o   (ready_up_o),
        .valid_down_o (valid_down_o),
        .data_down_o  (data_down_o),
        .ready_down_i (ready_down_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
`ifdef VALID_SERIALIZER_MSB_FIRST_EN
            exp_q.push_back(w[(3-k)*4 +: 4]);
`else
            exp_q.push_back(w[k*4 +: 4]);
`endif
        end
    endtask

    function automatic logic [3:0] next_exp();
        if (exp_q.size() == 0) return 4'bxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        valid_up_i = 1'b1; data_up_i = 16'h5A5A; ready_down_i = 1'b0;
        step();
        valid_up_i = 1'b0;
        n_tests++;
        if (valid_down_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_busy: valid_down=%b expected 1", valid_down_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if (valid_down_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: valid_down=%b expected 0", valid_down_o);
        end
        n_tests++;
        if (data_down_o !== 4'h0) begin
            n_fail++; $display("FAIL reset_data: data_down=%h expected 0", data_down_o);
        end
        n_tests++;
        if (ready_up_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: ready_up=%b expected 1", ready_up_o);
        end
        step();
        rst_ni = 1'b1;
        ready_down_i = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single();
        logic [3:0] e;
        valid_up_i = 1'b1; data_up_i = 16'hABCD; ready_down_i = 1'b1;
        n_tests++;
        if (ready_up_o !== 1'b1) begin
            n_fail++; $display("FAIL single_idle_ready: ready_up=%b expected 1", ready_up_o);
        end
        push_word(data_up_i);
        step();
        valid_up_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = next_exp();
            n_tests++;
            if (valid_down_o !== 1'b1) begin
                n_fail++; $display("FAIL single_valid[%0d]: valid_down=%b expected 1", i, valid_down_o);
            end
            n_tests++;
            if (data_down_o !== e) begin
                n_fail++; $display("FAIL single_data[%0d]: data_down=%h expected %h", i, data_down_o, e);
            end
            n_tests++;
            if (ready_up_o !== (i == 3)) begin
                n_fail++; $display("FAIL single_ready[%0d]: ready_up=%b expected %b", i, ready_up_o, (i == 3));
            end
            step();
        end
        n_tests++;
        if (valid_down_o !== 1'b0) begin
            n_fail++; $display("FAIL single_end: valid_down=%b expected 0", valid_down_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        logic       model_ru;
        logic       took;
        valid_up_i = 1'b1; data_up_i = 16'h1234; ready_down_i = 1'b1;
        push_word(data_up_i);
        step();
        data_up_i = 16'h5678;
        for (int i = 0; i < 8; i++) begin
            model_ru = (i % 4 == 3);
            e = next_exp();
            n_tests++;
            if (valid_down_o !== 1'b1) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: valid_down=%b expected 1", i, valid_down_o);
            end
            n_tests++;
            if (data_down_o !== e) begin
                n_fail++; $display("FAIL b2b_data[%0d]: data_down=%h expected %h", i, data_down_o, e);
            end
            n_tests++;
            if (ready_up_o !== model_ru) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: ready_up=%b expected %b", i, ready_up_o, model_ru);
            end
            took = valid_up_i && model_ru;
            if (took) push_word(data_up_i);
            step();
            if (took) valid_up_i = 1'b0;
        end
        n_tests++;
        if (valid_down_o !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_end: valid_down=%b left=%0d expected 0 and 0", valid_down_o, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] e;
        logic       rd;
        logic       model_ru;
        int         beat;
        logic [6:0] pattern;
        pattern = 7'b1110001;
        valid_up_i = 1'b1; data_up_i = 16'hABCD; ready_down_i = 1'b1;
        push_word(data_up_i);
        step();
        valid_up_i = 1'b0;
        beat = 0;
        for (int i = 0; i < 7; i++) begin
            rd = pattern[i];
            ready_down_i = rd;
            #1;
            model_ru = rd && (beat == 3);
            n_tests++;
            if (valid_down_o !== 1'b1) begin
                n_fail++; $display("FAIL bp_valid[%0d]: valid_down=%b expected 1", i, valid_down_o);
            end
            n_tests++;
            if (ready_up_o !== model_ru) begin
                n_fail++; $display("FAIL bp_ready[%0d]: ready_up=%b expected %b", i, ready_up_o, model_ru);
            end
            if (rd) begin
                e = next_exp();
                beat++;
            end else begin
                e = (exp_q.size() != 0) ? exp_q[0] : 4'bxxxx;
            end
            n_tests++;
            if (data_down_o !== e) begin
                n_fail++; $display("FAIL bp_data[%0d]: data_down=%h expected %h", i, data_down_o, e);
            end
            step();
        end
        ready_down_i = 1'b1;
        n_tests++;
        if (valid_down_o !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_end: valid_down=%b left=%0d expected 0 and 0", valid_down_o, exp_q.size());
        end
    endtask

    task automatic test_ignored();
        logic [3:0] e;
        logic       model_ru;
        valid_up_i = 1'b1; data_up_i = 16'h1234; ready_down_i = 1'b1;
        push_word(data_up_i);
        step();
        data_up_i = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            valid_up_i = (i < 3);
            #1;
            model_ru = (i == 3);
            e = next_exp();
            n_tests++;
            if (data_down_o !== e || valid_down_o !== 1'b1) begin
                n_fail++; $display("FAIL ign_data[%0d]: data_down=%h valid=%b expected %h 1", i, data_down_o, valid_down_o, e);
            end
            n_tests++;
            if (ready_up_o !== model_ru) begin
                n_fail++; $display("FAIL ign_ready[%0d]: ready_up=%b expected %b", i, ready_up_o, model_ru);
            end
            if (valid_up_i && model_ru) push_word(data_up_i);
            step();
        end
        valid_up_i = 1'b0;
        n_tests++;
        if (valid_down_o !== 1'b0) begin
            n_fail++; $display("FAIL ign_end: valid_down=%b expected 0", valid_down_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        valid_up_i = 1'b1; data_up_i = 16'hABCD; ready_down_i = 1'b1;
        push_word(data_up_i);
        step();
        valid_up_i = 1'b0;
        e = next_exp();
        step();
        e = next_exp();
        step();
        #2 rst_ni = 1'b0;
        #1;
        exp_q.delete();
        n_tests++;
        if (valid_down_o !== 1'b0 || data_down_o !== 4'h0 || ready_up_o !== 1'b1) begin
            n_fail++; $display("FAIL rmid_reset: valid=%b data=%h ready=%b expected 0 0 1", valid_down_o, data_down_o, ready_up_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        n_tests++;
        if (valid_down_o !== 1'b0) begin
            n_fail++; $display("FAIL rmid_idle: valid_down=%b expected 0", valid_down_o);
        end
        valid_up_i = 1'b1; data_up_i = 16'h0123;
        push_word(data_up_i);
        step();
        valid_up_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = next_exp();
            n_tests++;
            if (data_down_o !== e || valid_down_o !== 1'b1) begin
                n_fail++; $display("FAIL rmid_data[%0d]: data_down=%h valid=%b expected %h 1", i, data_down_o, valid_down_o, e);
            end
            step();
        end
        n_tests++;
        if (valid_down_o !== 1'b0) begin
            n_fail++; $display("FAIL rmid_end: valid_down=%b expected 0", valid_down_o);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        valid_up_i = 1'b0;
        data_up_i = 16'h0;
        ready_down_i = 1'b1;
        step();
        step();
        rst_ni = 1'b1;
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/valid_serializer.md
# valid_serializer

Width-downsizing handshake stage that sits directly downstream of the `valid_flop` register slice. It accepts one wide word of `width*ratio` bits per upstream handshake and emits it as `ratio` consecutive narrow beats of `width` bits on the downstream valid/ready interface. It sustains full narrow-side throughput: with `ready_down` held high it produces one beat per cycle with no bubble between words.

## Interface
- `width`, default 4: narrow beat width in bits.
- `ratio`, default 4: beats per wide word; legal values are ≥2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, **asynchronous and active-low**.
- `valid_up` input, 1 bit: wide word offered.
- `data_up` input, `width*ratio` bits: wide word.
- `ready_up` output, 1 bit: stage can accept a wide word this cycle.
- `valid_down` output, 1 bit: narrow beat offered.
- `data_down` output, `width` bits: narrow beat.
- `ready_down` input, 1 bit: downstream accepts the beat.

## Operation
- **State registers**
  - `buf_q`: `width*ratio` bits, holds the current word.
  - `cnt_q`: `$clog2(ratio)` bits, index of the beat currently presented.
  - `valid_down`: a flop.
- **Handshake events**
  - Up handshake: `valid_up && ready_up`.
  - Down handshake: `valid_down && ready_down`.
  - Last beat: `cnt_q == ratio-1`.
- **`ready_up`:** `ready_up = ~valid_down || (ready_down && last)`. It is combinational from `ready_down` only, and only during the last beat. There is no path from `valid_up` or `data_up` to any output.
- **`data_down`:** `buf_q[cnt_q*width +: width]`. It is a mux of registers only, with no combinational path from `data_up`.
- **Beat order:** beat 0 is the least significant slice (LSB first by default).
- **States**
  - IDLE: `valid_down=0`.
  - BUSY: `valid_down=1`.
- **Transitions, each clock edge, in priority order:**
  1. Up handshake:
     - `buf_q<=data_up`, `cnt_q<=0`, `valid_down<=1`.
     - This covers IDLE→BUSY, and also BUSY→BUSY when it coincides with the down handshake of the last beat.
  2. Down handshake with last beat and no up handshake: `valid_down<=0`, `cnt_q<=0`, and `buf_q` holds.
  3. Down handshake, not the last beat: `cnt_q<=cnt_q+1`.
  4. Otherwise, all registers hold.
- **Stall:** `valid_down` and `data_down` must stay stable while `ready_down=0`.
- **`valid_up` with `ready_up=0`:** ignored, and `buf_q` is unchanged.
- **Wrap:** `cnt_q` never exceeds `ratio-1`. When `ratio` is not a power of two, the counter resets to 0 after `ratio-1` instead of wrapping naturally.

## Timing
- **Reset:** asserting `rst=0` at any time, including mid-word, immediately (asynchronously) clears all of the following:
  - `valid_down=0`
  - `cnt_q=0`
  - `buf_q=0`, so `data_down=0`
  - `ready_up=1` follows combinationally.
  
  A partially sent word is discarded. The first edge after `rst` rises behaves as IDLE.
- **Latency:** first beat of a word appears on `valid_down`/`data_down` 1 cycle after the up handshake.
- **Throughput:** one word per `ratio` cycles with `ready_down=1` continuously. The next word's beat 0 appears in the cycle right after the last beat is accepted.
- **Backpressure:** each cycle of `ready_down=0` adds one cycle. `ready_up` stays low in BUSY until the last beat's down handshake cycle.
- **Simultaneous events:**
  - Last-beat down handshake together with an up handshake means reload with no bubble.
  - An up handshake in IDLE is always accepted.

## Configuration
- Macro `VALID_SERIALIZER_MSB_FIRST_EN`.
- **Undefined (default):** beat *k* is `buf_q[k*width +: width]`, i.e. LSB slice first.
- **Defined:** beat *k* is `buf_q[(ratio-1-k)*width +: width]`, i.e. MSB slice first.
- Handshake, timing and reset behaviour are identical in both builds.

## Test plan
All scenarios use `width=4`, `ratio=4`.
1. **Reset values:** `rst=0` asynchronously mid-cycle → `valid_down=0`, `data_down=4'h0` and `ready_up=1` with no clock edge required.
2. **Single word:** `data_up=16'hABCD` accepted with `ready_down=1` → beats D, C, B, A on 4 consecutive cycles starting 1 cycle after acceptance. Then `valid_down=0`. With the macro defined the beats are A, B, C, D.
3. **Back-to-back words:** `16'h1234` then `16'h5678` with `valid_up` and `ready_down` held at 1 → 8 consecutive beats 4, 3, 2, 1, 8, 7, 6, 5 with no gap. `ready_up=1` only in the last-beat cycles.
4. **Backpressure:** `ready_down=0` for 3 cycles during beat 1 of `16'hABCD` → `data_down` holds `4'hC` and `valid_down` holds 1 for those cycles, `ready_up=0` throughout, and no beat is lost or duplicated.
5. **Ignored offer:** `valid_up=1` with `16'hFFFF` while BUSY and not on the last beat → word is ignored and the current beats continue unchanged.
6. **Reset mid-word:** `rst=0` after beat 1 of `16'hABCD`, then released and `16'h0123` sent → output is 3, 2, 1, 0 only, with no residual B or A.
